// File: rtl/frame_downsample_ctrl.sv
// Crops a 16N x 16N window from the D5M pixel stream, box-averages each 16x16 block into one byte
// and writes the bytes to image_mem in raster order. Define DS_INVERT_EN to store 255-avg instead.
module frame_downsample_ctrl #(
  parameter int X0 = 96,
  parameter int Y0 = 16,
  parameter int N  = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        iFVAL,
  input  logic        iDVAL,
  input  logic [11:0] iGRAY,
  input  logic [15:0] iX,
  input  logic [15:0] iY,
  output logic        we,
  output logic [9:0]  waddr,
  output logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);
  // state   | meaning
  // IDLE    | waiting for go; done/err hold the result of the last capture
  // ARMED   | waiting for the next iFVAL rising edge (a frame in progress is skipped)
  // CAPTURE | accumulating window pixels and writing one byte per finished block

  localparam int          BXW  = (N > 1) ? $clog2(N) : 1;
  localparam logic [15:0] X0_L = 16'(X0);
  localparam logic [15:0] Y0_L = 16'(Y0);
  localparam logic [15:0] WIN  = 16'(16 * N);
  localparam logic [9:0]  LAST = 10'(N * N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2} state_t;
  state_t state, state_nxt;

  logic start_s1, start_s2, start_d, go;
  logic fval_d, fval_rise, fval_fall;
  logic [15:0] rx, ry;
  logic [BXW-1:0] bx;
  logic in_win, blk_first, blk_last, last_wr;
  logic [7:0] pix, avg;
  logic [15:0] sum;
  logic [15:0] acc [N];
  logic gray_unused;

  assign gray_unused = ^iGRAY[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_d  <= 1'b0;
      fval_d   <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_d  <= start_s2;
      fval_d   <= iFVAL;
    end
  end

  assign go        = start_s2 & ~start_d;
  assign fval_rise = iFVAL & ~fval_d;
  assign fval_fall = ~iFVAL & fval_d;

  assign rx        = iX - X0_L;
  assign ry        = iY - Y0_L;
  assign bx        = rx[4 +: BXW];
  assign pix       = iGRAY[11:4];
  assign in_win    = iDVAL && (state == CAPTURE) && (iX >= X0_L) && (rx < WIN) &&
                     (iY >= Y0_L) && (ry < WIN);
  assign blk_first = (rx[3:0] == 4'h0) && (ry[3:0] == 4'h0);
  assign blk_last  = (rx[3:0] == 4'hF) && (ry[3:0] == 4'hF);
  assign sum       = acc[bx] + {8'd0, pix};
  assign last_wr   = we && (waddr == LAST);

`ifdef DS_INVERT_EN
  assign avg = 8'd255 - sum[15:8];
`else
  assign avg = sum[15:8];
`endif

  // One accumulator per block column; the first pixel of a block reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (in_win) begin
      acc[bx] <= blk_first ? {8'd0, pix} : sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = ARMED;
      ARMED:   if (fval_rise) state_nxt = CAPTURE;
      CAPTURE: if (last_wr || fval_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ARMED) || (state == CAPTURE);
  end

  // Completion wins over a coincident frame end so the final write still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      we <= in_win && blk_last;
      if (in_win && blk_last) wdata <= avg;
      if (state == ARMED && fval_rise) waddr <= '0;
      else if (we)                     waddr <= waddr + 10'd1;
      if (state == IDLE && go) begin
        done <= 1'b0;
        err  <= 1'b0;
      end else if (state == CAPTURE) begin
        if (last_wr)        done <= 1'b1;
        else if (fval_fall) err  <= 1'b1;
      end
    end
  end

endmodule
